// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes little-endian words
// into instruction memory, verifies an XOR checksum and then releases the core.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [16:0] word_idx;
  logic [15:0] n;
  logic [7:0]  xor_acc;
  logic [23:0] shreg;

  logic        accept;
  logic [15:0] n_full;
  logic [31:0] word_next;

  assign rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CSUM);
  assign accept   = rx_valid & rx_ready;

  // Lane 3 comes straight from the bus so the word can be written the next cycle.
  always_comb begin
    word_next = {rx_data, shreg};
    n_full    = {rx_data, n[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LEN_LO;
      byte_idx     <= '0;
      word_idx     <= '0;
      n            <= '0;
      xor_acc      <= '0;
      shreg        <= '0;
      core_rst     <= 1'b1;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_LEN_LO: begin
          if (accept) begin
            n[7:0]  <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
            state   <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            n[15:8] <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
            if ({1'b0, n_full} > CAPACITY) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else if (n_full == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            xor_acc  <= xor_acc ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: shreg[7:0]   <= rx_data;
              2'd1: shreg[15:8]  <= rx_data;
              2'd2: shreg[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_waddr <= word_idx[ADDR_W-1:0];
                imem_wdata <= word_next;
                state      <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          imem_we      <= 1'b0;
          word_idx     <= word_idx + 17'd1;
          words_loaded <= words_loaded + 16'd1;
          if (word_idx + 17'd1 == {1'b0, n}) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end

        S_CSUM: begin
          if (accept) begin
            if (rx_data == xor_acc) begin
              state     <= S_DONE;
              core_rst  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end

        S_DONE, S_ERR: begin
          state <= state;
        end

        default: begin
          state     <= S_ERR;
          core_rst  <= 1'b1;
          load_done <= 1'b0;
          load_err  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and random image streams
// compared against a stream-level reference model.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .core_rst    (core_rst),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_words[$];
  bit          exp_done;
  bit          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decode the whole stream into expected words and final verdict.
  task automatic build_model();
    int n;
    logic [7:0] x;
    exp_words.delete();
    n = {stream[1], stream[0]};
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (n > CAP) return;
    x = stream[0] ^ stream[1];
    for (int i = 0; i < n; i++) begin
      exp_words.push_back({stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]});
      for (int k = 0; k < 4; k++) x ^= stream[2+4*i+k];
    end
    exp_done = (stream[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  task automatic append_csum(input bit good);
    logic [7:0] x = '0;
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic make_random(input int n, input bit good);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom_range(0, 255)));
    append_csum(good);
  endtask

  task automatic make_two_word(input bit good);
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    append_csum(good);
  endtask

  // Per-cycle write check: a write must appear exactly one cycle after a word's 4th byte.
  task automatic mon(input bit pend, inout int wi);
    chk("we_timing", imem_we, pend);
    if (imem_we === 1'b1) begin
      chk("ready_in_write", rx_ready, 0);
      chk("waddr", imem_waddr, wi);
      if (wi < exp_words.size()) chk("wdata", imem_wdata, exp_words[wi]);
      else chk("extra_write", imem_we, 0);
      wi++;
    end
  endtask

  task automatic run(input int nbytes, input bit throttle, output int nw);
    int idx = 0;
    int cyc = 0;
    int n;
    bit pend = 1'b0;
    nw = 0;
    n = {stream[1], stream[0]};
    while (idx < nbytes && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      mon(pend, nw);
      pend = 1'b0;
      rx_valid = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      rx_data  = rx_valid ? stream[idx] : 8'($urandom_range(0, 255));
      if (rx_valid && rx_ready) begin
        if (idx >= 2 && idx < 2 + 4*n && ((idx - 2) % 4) == 3) pend = 1'b1;
        idx++;
      end
    end
    chk("bytes_consumed", idx, nbytes);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mon(pend, nw);
      pend = 1'b0;
      rx_valid = 1'b0;
    end
  endtask

  task automatic check_end(input int nw);
    chk("load_done", load_done, exp_done);
    chk("load_err", load_err, exp_err);
    chk("core_rst", core_rst, !exp_done);
    chk("words_loaded", words_loaded, exp_words.size());
    chk("write_count", nw, exp_words.size());
    chk("rx_ready_end", rx_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_ready", rx_ready, 1);
  endtask

  task automatic full_load(input bit throttle);
    int nw;
    build_model();
    run(stream.size(), throttle, nw);
    check_end(nw);
  endtask

  initial begin
    int nw;

    do_reset();
    chk_reset_vals();

    make_two_word(1'b1);
    full_load(1'b0);

    do_reset();
    make_two_word(1'b1);
    full_load(1'b1);

    do_reset();
    make_two_word(1'b0);
    full_load(1'b0);

    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    full_load(1'b0);

    do_reset();
    stream = '{8'h00, 8'h00, 8'h01};
    full_load(1'b1);

    do_reset();
    stream = '{8'h01, 8'h04};
    build_model();
    run(2, 1'b0, nw);
    check_end(nw);

    // Reset after five data bytes, then a clean load from address 0.
    do_reset();
    make_two_word(1'b1);
    build_model();
    run(7, 1'b1, nw);
    chk("partial_writes", nw, 1);
    chk("partial_words", words_loaded, 1);
    do_reset();
    chk_reset_vals();
    make_two_word(1'b1);
    full_load(1'b0);

    do_reset();
    make_random(CAP, 1'b1);
    full_load(1'b0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      make_random($urandom_range(1, 12), ($urandom_range(0, 3) != 0));
      full_load($urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
